// File: rtl/bus_initiator.sv
// bus_initiator: single-outstanding bus master; latches a command, strobes req once,
// waits for resp/fault or a timeout, then reports one registered completion pulse.
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_1B
`define BUS_ACC_1B 2'd0
`define BUS_ACC_2B 2'd1
`define BUS_ACC_4B 2'd2
`endif

module bus_initiator #(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                      clk,
  input  logic                      rst_i,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic                      cmd_w_rb,
  input  logic [`BUS_ACC_WIDTH-1:0] cmd_acc,
  input  logic [`BUS_WIDTH-1:0]     cmd_wdata,
  output logic                      rsp_valid,
  output logic [`BUS_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                rsp_err,
  output logic [ADDR_WIDTH-1:0]     addr,
  output logic                      w_rb,
  output logic [`BUS_ACC_WIDTH-1:0] acc,
  output logic [`BUS_WIDTH-1:0]     wdata,
  output logic                      req,
  input  logic [`BUS_WIDTH-1:0]     rdata,
  input  logic                      resp,
  input  logic                      fault
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic w_rb_q, w_rb_d;
  logic [`BUS_ACC_WIDTH-1:0] acc_q, acc_d;
  logic [`BUS_WIDTH-1:0] wdata_q, wdata_d, rsp_rdata_q, rsp_rdata_d;
  logic [1:0] rsp_err_q, rsp_err_d;
  logic ready_q, req_q, rsp_valid_q;
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    w_rb_d      = w_rb_q;
    acc_d       = acc_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        state_d = REQ;
        addr_d  = cmd_addr;
        w_rb_d  = cmd_w_rb;
        acc_d   = cmd_acc;
        wdata_d = cmd_wdata;
      end
      REQ: if (fault) begin
        state_d     = DONE;
        rsp_err_d   = 2'b01;
        rsp_rdata_d = '0;
      end else if (resp) begin
        state_d     = DONE;
        rsp_err_d   = 2'b00;
        rsp_rdata_d = w_rb_q ? '0 : rdata;
      end else begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: if (resp) begin
        state_d     = DONE;
        rsp_err_d   = 2'b00;
        rsp_rdata_d = w_rb_q ? '0 : rdata;
      end else if (cnt_q == 16'(TIMEOUT - 1)) begin
        state_d     = DONE;
        rsp_err_d   = 2'b10;
        rsp_rdata_d = '0;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
      DONE: state_d = IDLE;
    endcase
  end
  // Strobes are decoded from the next state so every output comes straight off a flop.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      w_rb_q      <= 1'b0;
      acc_q       <= '0;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 2'b00;
      ready_q     <= 1'b1;
      req_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      w_rb_q      <= w_rb_d;
      acc_q       <= acc_d;
      wdata_q     <= wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      ready_q     <= state_d == IDLE;
      req_q       <= state_d == REQ;
      rsp_valid_q <= state_d == DONE;
    end
  end
  assign cmd_ready = ready_q;
  assign req       = req_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign addr      = addr_q;
  assign w_rb      = w_rb_q;
  assign acc       = acc_q;
  assign wdata     = wdata_q;
endmodule

// File: tb/tb_bus_initiator.sv
// tb_bus_initiator: scenario tasks with a completion scoreboard for bus_initiator (TIMEOUT=4).
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_1B
`define BUS_ACC_1B 2'd0
`define BUS_ACC_2B 2'd1
`define BUS_ACC_4B 2'd2
`endif

module tb_bus_initiator;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_i = 1'b1, cmd_valid = 1'b0, cmd_ready, cmd_w_rb = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0, rsp_rdata, addr, wdata, rdata = '0;
  logic [1:0] cmd_acc = '0, acc, rsp_err;
  logic rsp_valid, w_rb, req, resp = 1'b0, fault = 1'b0;

  bus_initiator #(.ADDR_WIDTH(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst_i(rst_i), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_w_rb(cmd_w_rb), .cmd_acc(cmd_acc), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .addr(addr), .w_rb(w_rb), .acc(acc), .wdata(wdata), .req(req),
    .rdata(rdata), .resp(resp), .fault(fault)
  );

  typedef struct {logic [31:0] rdata; logic [1:0] err; int lat;} exp_t;
  exp_t sb[$];
  int checks = 0, failures = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives one command from IDLE; resp_at/fault are in cycles after the handshake (cycle 0).
  task automatic run_txn(input logic [31:0] a, input logic wr, input logic [1:0] ac,
                         input logic [31:0] wd, input int resp_at, input bit flt,
                         input bit flt_late, input logic [31:0] rd, output bit got,
                         output int lat, output logic [31:0] ord, output logic [1:0] oerr,
                         output int nreq, output int nrdy, output bit stable);
    got = 0; lat = -1; ord = 'x; oerr = 'x; nreq = 0; nrdy = 0; stable = 1;
    cmd_valid = 1; cmd_addr = a; cmd_w_rb = wr; cmd_acc = ac; cmd_wdata = wd;
    tick();
    cmd_valid = 0; cmd_addr = $urandom; cmd_w_rb = ~wr; cmd_acc = ~ac; cmd_wdata = $urandom;
    for (int c = 1; c < 20; c++) begin
      nreq += int'(req);
      nrdy += int'(cmd_ready);
      if (addr !== a || w_rb !== wr || acc !== ac || wdata !== wd) stable = 0;
      if (rsp_valid) begin
        got = 1; lat = c; ord = rsp_rdata; oerr = rsp_err;
        break;
      end
      resp  = (c == resp_at);
      fault = (flt && c == 1) || (flt_late && c >= 2);
      rdata = resp ? rd : $urandom;
      tick();
    end
    resp = 0; fault = 0;
  endtask

  task automatic scen(input string nm, input logic [31:0] a, input logic wr, input logic [1:0] ac,
                      input logic [31:0] wd, input int resp_at, input bit flt, input bit flt_late,
                      input logic [31:0] rd, input logic [31:0] x_rd, input logic [1:0] x_err,
                      input int x_lat);
    bit got, stable;
    int lat, nreq, nrdy;
    logic [31:0] ord;
    logic [1:0] oerr;
    exp_t e;
    sb.push_back('{x_rd, x_err, x_lat});
    run_txn(a, wr, ac, wd, resp_at, flt, flt_late, rd, got, lat, ord, oerr, nreq, nrdy, stable);
    e = sb.pop_front();
    checks++;
    if (!got) begin
      failures++; $display("FAIL %s no rsp_valid within budget", nm);
    end else begin
      checks += 3;
      if (lat !== e.lat) begin failures++; $display("FAIL %s latency got=%0d exp=%0d", nm, lat, e.lat); end
      if (ord !== e.rdata) begin failures++; $display("FAIL %s rsp_rdata got=%h exp=%h", nm, ord, e.rdata); end
      if (oerr !== e.err) begin failures++; $display("FAIL %s rsp_err got=%b exp=%b", nm, oerr, e.err); end
    end
    checks += 3;
    if (nreq !== 1) begin failures++; $display("FAIL %s req cycles got=%0d exp=1", nm, nreq); end
    if (nrdy !== 0) begin failures++; $display("FAIL %s cmd_ready busy cycles got=%0d exp=0", nm, nrdy); end
    if (!stable) begin failures++; $display("FAIL %s bus fields unstable got=0 exp=1", nm); end
    tick();
    checks++;
    if (rsp_valid !== 0 || cmd_ready !== 1 || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
      failures++;
      $display("FAIL %s post-done hold got v=%b rdy=%b rd=%h err=%b exp v=0 rdy=1 rd=%h err=%b",
               nm, rsp_valid, cmd_ready, rsp_rdata, rsp_err, e.rdata, e.err);
    end
  endtask

  task automatic test_reset;
    rst_i = 1;
    tick(); tick();
    rst_i = 0;
    checks++;
    if (cmd_ready !== 1 || req !== 0 || rsp_valid !== 0 || rsp_err !== 0 || rsp_rdata !== 0 ||
        addr !== 0 || w_rb !== 0 || acc !== 0 || wdata !== 0) begin
      failures++;
      $display("FAIL reset got rdy=%b req=%b v=%b err=%b rd=%h addr=%h w=%b acc=%b wd=%h exp rdy=1 rest 0",
               cmd_ready, req, rsp_valid, rsp_err, rsp_rdata, addr, w_rb, acc, wdata);
    end
  endtask

  task automatic test_basic;
    scen("write_1b", 32'h0, 1, `BUS_ACC_1B, 32'h3, 2, 0, 0, 32'h1234_5678, 32'h0, 2'b00, 3);
    scen("read_4b", 32'h10, 0, `BUS_ACC_4B, 32'h0, 5, 0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b00, 6);
    scen("fault_2b", 32'h22, 0, `BUS_ACC_2B, 32'h0, 1, 1, 0, 32'hAAAA_5555, 32'h0, 2'b01, 2);
    scen("fault_wait_ignored", 32'h30, 0, `BUS_ACC_4B, 32'h0, 3, 0, 1, 32'h0BAD_F00D, 32'h0BAD_F00D, 2'b00, 4);
    scen("resp_last_wait", 32'h40, 0, `BUS_ACC_4B, 32'h0, 5, 0, 0, 32'h7777_1111, 32'h7777_1111, 2'b00, 6);
  endtask

  task automatic test_timeout;
    scen("timeout", 32'h50, 0, `BUS_ACC_4B, 32'h0, -1, 0, 0, 32'h0, 32'h0, 2'b10, 6);
    resp = 1; fault = 1; rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (rsp_valid !== 0 || cmd_ready !== 1 || rsp_err !== 2'b10 || rsp_rdata !== 0) begin
        failures++;
        $display("FAIL stray_resp cycle %0d got v=%b rdy=%b err=%b rd=%h exp v=0 rdy=1 err=10 rd=0",
                 i, rsp_valid, cmd_ready, rsp_err, rsp_rdata);
      end
    end
    resp = 0; fault = 0;
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int seen = 0;
    sb.push_back('{32'hCAFE_F00D, 2'b00, 2});
    sb.push_back('{32'h0, 2'b00, 5});
    cmd_valid = 1; cmd_addr = 32'h100; cmd_w_rb = 0; cmd_acc = `BUS_ACC_4B; cmd_wdata = 32'h9;
    tick();
    resp = 1; rdata = 32'hCAFE_F00D;
    cmd_addr = 32'h204; cmd_w_rb = 1; cmd_acc = `BUS_ACC_2B; cmd_wdata = 32'h55AA;
    for (int c = 1; c < 12; c++) begin
      if (c == 4) cmd_valid = 0;
      if (c == 3 || c == 4) begin
        checks++;
        if (cmd_ready !== (c == 3) || req !== (c == 4)) begin
          failures++;
          $display("FAIL b2b cycle %0d got rdy=%b req=%b exp rdy=%b req=%b", c, cmd_ready, req, c == 3, c == 4);
        end
      end
      if (c >= 1 && c <= 3) begin
        checks++;
        if (addr !== 32'h100 || w_rb !== 0 || acc !== `BUS_ACC_4B || wdata !== 32'h9) begin
          failures++; $display("FAIL b2b fields_a cycle %0d got addr=%h w=%b", c, addr, w_rb);
        end
      end
      if (c >= 4 && c <= 5) begin
        checks++;
        if (addr !== 32'h204 || w_rb !== 1 || acc !== `BUS_ACC_2B || wdata !== 32'h55AA) begin
          failures++; $display("FAIL b2b fields_b cycle %0d got addr=%h w=%b", c, addr, w_rb);
        end
      end
      if (rsp_valid) begin
        e = sb.pop_front();
        seen++;
        checks++;
        if (c !== e.lat || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
          failures++;
          $display("FAIL b2b rsp%0d got cyc=%0d rd=%h err=%b exp cyc=%0d rd=%h err=%b",
                   seen, c, rsp_rdata, rsp_err, e.lat, e.rdata, e.err);
        end
      end
      resp = (c == 1 || c == 4);
      rdata = (c == 1) ? 32'hCAFE_F00D : 32'h1357_9BDF;
      tick();
    end
    resp = 0;
    checks++;
    if (seen !== 2) begin failures++; $display("FAIL b2b completions got=%0d exp=2", seen); end
    sb.delete();
  endtask

  task automatic test_reset_mid;
    cmd_valid = 1; cmd_addr = 32'h60; cmd_w_rb = 0; cmd_acc = `BUS_ACC_4B;
    tick();
    cmd_valid = 0;
    tick(); tick();
    rst_i = 1; cmd_valid = 1; resp = 1; fault = 1; rdata = 32'h1111_2222;
    tick();
    rst_i = 0; cmd_valid = 0; fault = 0;
    checks++;
    if (cmd_ready !== 1 || req !== 0 || rsp_valid !== 0 || addr !== 0 || rsp_err !== 0 || rsp_rdata !== 0) begin
      failures++;
      $display("FAIL reset_mid got rdy=%b req=%b v=%b addr=%h err=%b rd=%h exp rdy=1 rest 0",
               cmd_ready, req, rsp_valid, addr, rsp_err, rsp_rdata);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      resp = 0;
      checks++;
      if (rsp_valid !== 0 || req !== 0 || cmd_ready !== 1) begin
        failures++;
        $display("FAIL reset_late_resp cycle %0d got v=%b req=%b rdy=%b exp v=0 req=0 rdy=1",
                 i, rsp_valid, req, cmd_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    scen("after_reset", 32'h70, 0, `BUS_ACC_1B, 32'h0, 3, 0, 0, 32'h0000_00A5, 32'h0000_00A5, 2'b00, 4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
